contador_comida: RTL and testbench
==================================

CONTADOR_COMIDA -- requirements
Module: Contador_Comida

Interface
REQ-001 The module SHALL have parameter CICLOS_DECAY, default 250: clock cycles per one-step hunger decay.
REQ-002 The module SHALL have parameter CICLOS_COMER, default 50: clock cycles of continuous feeding per one-step level increase.
REQ-003 The module SHALL have parameter CICLOS_ANTIRREBOTE, default 4: cycles of stable synchronized input needed to accept a button change.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 The module SHALL have port Boton_Comida, input, 1 bit: raw, asynchronous, bouncing feed button (1 = pressed).
REQ-007 The module SHALL have port Activo_Comida, input, 1 bit: feed enable from the downstream state machine (1 = feeding allowed).
REQ-008 The module SHALL have port Sensor_Luz, input, 1 bit: 1 = light (awake), 0 = dark (asleep, decay frozen).
REQ-009 The module SHALL have port Nivel_Comida, output, 2 bits: registered food level, 0 (starving) to 3 (full).
REQ-010 The module SHALL have port Comiendo, output, 1 bit: registered, 1 while in state COMIENDO.
REQ-011 The module SHALL have port Pulso_Decay, output, 1 bit: one-cycle pulse for each decrement of Nivel_Comida.

Function
REQ-012 Boton_Comida SHALL pass through a 2-flop synchronizer, then a debounce counter; the filtered signal Boton_F takes the synchronized value only after it has differed from Boton_F for CICLOS_ANTIRREBOTE consecutive cycles; any mismatch-free cycle clears the counter.
REQ-013 The FSM SHALL have three states: NORMAL, COMIENDO, LLENO.
REQ-014 In NORMAL, a free-running decay counter SHALL increment each cycle while Sensor_Luz=1 and hold while Sensor_Luz=0.
REQ-015 On a decay counter value of CICLOS_DECAY-1, the counter SHALL wrap to 0 and Nivel_Comida SHALL decrement by 1 if >0, saturating at 0.
REQ-016 Pulso_Decay SHALL be 1 for exactly the cycle in which the decremented Nivel_Comida first appears; a wrap at level 0 SHALL produce no pulse.
REQ-017 NORMAL -> COMIENDO SHALL occur when Boton_F=1, Activo_Comida=1 and Nivel_Comida<3; the eat counter and decay counter SHALL clear on entry.
REQ-018 NORMAL -> LLENO SHALL occur when Boton_F=1 and Nivel_Comida=3, with no level change and Comiendo remaining 0.
REQ-019 In COMIENDO, the eat counter SHALL increment each cycle; at CICLOS_COMER-1 it SHALL wrap to 0 and Nivel_Comida SHALL increment by 1.
REQ-020 In COMIENDO, when an increment makes Nivel_Comida 3, the FSM SHALL go to LLENO in the same cycle.
REQ-021 In COMIENDO, Boton_F=0 or Activo_Comida=0 SHALL return the FSM to NORMAL; that cycle SHALL NOT increment, and partial eat progress SHALL be discarded (eat counter cleared).
REQ-022 Release of the button SHALL take priority over an increment falling in the same cycle.
REQ-023 Decay SHALL be frozen (counter held, no decrement) in COMIENDO and LLENO.
REQ-024 LLENO SHALL go to NORMAL when Boton_F=0, clearing the decay counter.
REQ-025 Nivel_Comida SHALL never wrap: never below 0, never above 3.
REQ-026 Counter widths SHALL be $clog2 of their parameter, minimum 1 bit.
REQ-027 Latency from a clean raw press to Comiendo=1 SHALL be 2 + CICLOS_ANTIRREBOTE + 1 cycles.

Reset
REQ-028 reset=0 SHALL asynchronously force Nivel_Comida=3, Comiendo=0, Pulso_Decay=0, state NORMAL, all counters, synchronizer flops and Boton_F to 0.
REQ-029 Reset asserted mid-feeding or mid-decay SHALL abandon all progress; after release, operation SHALL restart from the REQ-028 values on the first rising clk edge.

Verification (CICLOS_DECAY=8, CICLOS_COMER=4, CICLOS_ANTIRREBOTE=3)
REQ-030 Decay test: reset release, Sensor_Luz=1, button idle -> Nivel_Comida 3->2->1->0 at 8-cycle intervals; exactly 3 Pulso_Decay pulses, then the level stays 0.
REQ-031 Dark test: Nivel_Comida=2 with Sensor_Luz=0 for 100 cycles -> no change and no pulse; Sensor_Luz=1 -> decay resumes from the held count.
REQ-032 Feeding test: Nivel_Comida=0, Activo_Comida=1, button held -> Comiendo=1 after 6 cycles; level 1, 2, 3 at 4-cycle steps; then LLENO with Comiendo=0; release -> NORMAL.
REQ-033 Bounce and abort test: button toggles every 2 cycles -> Boton_F never changes. Separately, at Nivel_Comida=1, release after 3 eat cycles -> level stays 1, state NORMAL.
REQ-034 Enable and reset test: Activo_Comida=0 with button held -> no feeding. Separately, reset=0 pulse during COMIENDO at level 2 -> immediately Nivel_Comida=3, Comiendo=0.

Source files
------------

// File: rtl/contador_comida.sv
// contador_comida: food level counter for the virtual pet.
// Hunger decays while the room is lit; holding the (debounced) feed button
// while the downstream FSM allows it raises the level one step per
// CICLOS_COMER cycles until full.
module contador_comida #(
    parameter int CICLOS_DECAY      = 250,
    parameter int CICLOS_COMER      = 50,
    parameter int CICLOS_ANTIRREBOTE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Boton_Comida,
    input  logic       Activo_Comida,
    input  logic       Sensor_Luz,
    output logic [1:0] Nivel_Comida,
    output logic       Comiendo,
    output logic       Pulso_Decay
);

    // Counter widths: $clog2 of the period, never narrower than one bit.
    localparam int W_DECAY = (CICLOS_DECAY > 1)       ? $clog2(CICLOS_DECAY)       : 1;
    localparam int W_COMER = (CICLOS_COMER > 1)       ? $clog2(CICLOS_COMER)       : 1;
    localparam int W_REB   = (CICLOS_ANTIRREBOTE > 1) ? $clog2(CICLOS_ANTIRREBOTE) : 1;

    localparam logic [W_DECAY-1:0] DECAY_MAX = W_DECAY'(CICLOS_DECAY - 1);
    localparam logic [W_COMER-1:0] COMER_MAX = W_COMER'(CICLOS_COMER - 1);
    localparam logic [W_REB-1:0]   REB_MAX   = W_REB'(CICLOS_ANTIRREBOTE - 1);

    localparam logic [1:0] NIVEL_LLENO = 2'd3;

    // FSM encodings
    localparam logic [1:0] ST_NORMAL   = 2'd0;
    localparam logic [1:0] ST_COMIENDO = 2'd1;
    localparam logic [1:0] ST_LLENO    = 2'd2;

    // Synchronizer and debounce state
    logic             sync1_q, sync2_q;
    logic             boton_f_q, boton_f_d;
    logic [W_REB-1:0] cnt_reb_q, cnt_reb_d;

    // Main FSM and counters
    logic [1:0]         state_q, state_d;
    logic [1:0]         nivel_q, nivel_d;
    logic [W_DECAY-1:0] cnt_decay_q, cnt_decay_d;
    logic [W_COMER-1:0] cnt_comer_q, cnt_comer_d;
    logic               comiendo_q;
    logic               pulso_q, pulso_d;

    // Two-flop synchronizer for the asynchronous raw button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= Boton_Comida;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept the synchronized value once it has disagreed with the
    // filtered value for CICLOS_ANTIRREBOTE consecutive cycles
    always_comb begin
        boton_f_d = boton_f_q;
        cnt_reb_d = '0;
        if (sync2_q != boton_f_q) begin
            if (cnt_reb_q == REB_MAX) begin
                boton_f_d = sync2_q;
                cnt_reb_d = '0;
            end else begin
                cnt_reb_d = cnt_reb_q + 1'b1;
            end
        end
    end

    // Debounce registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            boton_f_q <= 1'b0;
            cnt_reb_q <= '0;
        end else begin
            boton_f_q <= boton_f_d;
            cnt_reb_q <= cnt_reb_d;
        end
    end

    // FSM next state, level update, decay and eat counters
    always_comb begin
        state_d     = state_q;
        nivel_d     = nivel_q;
        cnt_decay_d = cnt_decay_q;
        cnt_comer_d = cnt_comer_q;
        pulso_d     = 1'b0;

        case (state_q)
            ST_NORMAL: begin
                if (boton_f_q && (nivel_q == NIVEL_LLENO)) begin
                    // Already full: park in LLENO without eating
                    state_d = ST_LLENO;
                end else if (boton_f_q && Activo_Comida) begin
                    state_d     = ST_COMIENDO;
                    cnt_comer_d = '0;
                    cnt_decay_d = '0;
                end else if (Sensor_Luz) begin
                    if (cnt_decay_q == DECAY_MAX) begin
                        cnt_decay_d = '0;
                        if (nivel_q != 2'd0) begin
                            nivel_d = nivel_q - 2'd1;
                            pulso_d = 1'b1;
                        end
                    end else begin
                        cnt_decay_d = cnt_decay_q + 1'b1;
                    end
                end
            end

            ST_COMIENDO: begin
                // Release/disable is checked first so it beats a pending increment
                if (!boton_f_q || !Activo_Comida) begin
                    state_d     = ST_NORMAL;
                    cnt_comer_d = '0;
                end else if (cnt_comer_q == COMER_MAX) begin
                    cnt_comer_d = '0;
                    if (nivel_q >= 2'd2) begin
                        nivel_d = NIVEL_LLENO;
                        state_d = ST_LLENO;
                    end else begin
                        nivel_d = nivel_q + 2'd1;
                    end
                end else begin
                    cnt_comer_d = cnt_comer_q + 1'b1;
                end
            end

            ST_LLENO: begin
                if (!boton_f_q) begin
                    state_d     = ST_NORMAL;
                    cnt_decay_d = '0;
                end
            end

            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    // FSM, level and counter registers; outputs are registered here too
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_NORMAL;
            nivel_q     <= NIVEL_LLENO;
            cnt_decay_q <= '0;
            cnt_comer_q <= '0;
            comiendo_q  <= 1'b0;
            pulso_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            nivel_q     <= nivel_d;
            cnt_decay_q <= cnt_decay_d;
            cnt_comer_q <= cnt_comer_d;
            comiendo_q  <= (state_d == ST_COMIENDO);
            pulso_q     <= pulso_d;
        end
    end

    assign Nivel_Comida = nivel_q;
    assign Comiendo     = comiendo_q;
    assign Pulso_Decay  = pulso_q;

endmodule

// File: tb/tb_contador_comida.sv
// Directed testbench for contador_comida with short periods
// (decay 8, eat 4, debounce 3).
module tb_contador_comida;

    logic       clk;
    logic       reset;
    logic       Boton_Comida;
    logic       Activo_Comida;
    logic       Sensor_Luz;
    logic [1:0] Nivel_Comida;
    logic       Comiendo;
    logic       Pulso_Decay;

    int errors = 0;
    int checks = 0;

    contador_comida #(
        .CICLOS_DECAY      (8),
        .CICLOS_COMER      (4),
        .CICLOS_ANTIRREBOTE(3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Boton_Comida (Boton_Comida),
        .Activo_Comida(Activo_Comida),
        .Sensor_Luz   (Sensor_Luz),
        .Nivel_Comida (Nivel_Comida),
        .Comiendo     (Comiendo),
        .Pulso_Decay  (Pulso_Decay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset with idle inputs; released 1 unit after an edge
    task automatic apply_reset();
        reset         = 1'b0;
        Boton_Comida  = 1'b0;
        Activo_Comida = 1'b0;
        Sensor_Luz    = 1'b1;
        tick(2);
        reset = 1'b1;
    endtask

    initial begin
        int pulses;
        int bad;
        int exp_lvl;
        int exp_p;

        reset         = 1'b0;
        Boton_Comida  = 1'b0;
        Activo_Comida = 1'b0;
        Sensor_Luz    = 1'b1;

        // ---- Reset values
        tick(2);
        chk("rst_nivel", Nivel_Comida, 3);
        chk("rst_comiendo", Comiendo, 0);
        chk("rst_pulso", Pulso_Decay, 0);

        // ---- Decay: 3 -> 2 -> 1 -> 0 every 8 cycles, exactly 3 pulses
        apply_reset();
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (Pulso_Decay) pulses++;
            exp_lvl = (i >= 24) ? 0 : 3 - i / 8;
            exp_p   = (i == 8 || i == 16 || i == 24) ? 1 : 0;
            chk($sformatf("decay_lvl_c%0d", i), Nivel_Comida, exp_lvl);
            chk($sformatf("decay_pulse_c%0d", i), Pulso_Decay, exp_p);
        end
        chk("decay_npulses", pulses, 3);

        // ---- Dark: level 2, count 3, 100 dark cycles hold everything
        apply_reset();
        tick(8);
        chk("dark_pre_lvl", Nivel_Comida, 2);
        tick(3);
        Sensor_Luz = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (Nivel_Comida != 2'd2 || Pulso_Decay) bad++;
        end
        chk("dark_hold", bad, 0);
        Sensor_Luz = 1'b1;
        tick(4);
        chk("dark_resume_lvl_a", Nivel_Comida, 2);
        tick(1);
        chk("dark_resume_lvl_b", Nivel_Comida, 1);
        chk("dark_resume_pulse", Pulso_Decay, 1);

        // ---- Feeding from level 0 up to full, then release
        apply_reset();
        tick(24);
        chk("feed_start_lvl", Nivel_Comida, 0);
        Activo_Comida = 1'b1;
        Boton_Comida  = 1'b1;
        tick(5);
        chk("feed_lat_c5", Comiendo, 0);
        tick(1);
        chk("feed_lat_c6", Comiendo, 1);
        tick(3);
        chk("feed_c9_lvl", Nivel_Comida, 0);
        tick(1);
        chk("feed_c10_lvl", Nivel_Comida, 1);
        tick(4);
        chk("feed_c14_lvl", Nivel_Comida, 2);
        tick(3);
        chk("feed_c17_lvl", Nivel_Comida, 2);
        chk("feed_c17_com", Comiendo, 1);
        tick(1);
        chk("feed_c18_lvl", Nivel_Comida, 3);
        chk("feed_c18_com", Comiendo, 0);
        tick(5);
        chk("lleno_hold_lvl", Nivel_Comida, 3);
        chk("lleno_hold_com", Comiendo, 0);
        Boton_Comida = 1'b0;
        tick(13);
        chk("lleno_exit_lvl_a", Nivel_Comida, 3);
        tick(1);
        chk("lleno_exit_lvl_b", Nivel_Comida, 2);
        chk("lleno_exit_pulse", Pulso_Decay, 1);

        // ---- Bounce: button toggles every 2 cycles, filter never moves
        apply_reset();
        tick(8);
        chk("bounce_pre_lvl", Nivel_Comida, 2);
        Activo_Comida = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            Boton_Comida = (((i >> 1) & 1) == 0);
            tick(1);
            if (Comiendo) bad++;
        end
        Boton_Comida = 1'b0;
        chk("bounce_no_eat", bad, 0);
        chk("bounce_decay_lvl", Nivel_Comida, 0);

        // ---- Abort at level 1: release lands on the increment cycle
        apply_reset();
        tick(16);
        chk("abort_pre_lvl", Nivel_Comida, 1);
        Activo_Comida = 1'b1;
        Boton_Comida  = 1'b1;
        tick(4);
        Boton_Comida = 1'b0;
        tick(2);
        chk("abort_c6_com", Comiendo, 1);
        tick(3);
        chk("abort_c9_com", Comiendo, 1);
        chk("abort_c9_lvl", Nivel_Comida, 1);
        tick(1);
        chk("abort_c10_com", Comiendo, 0);
        chk("abort_c10_lvl", Nivel_Comida, 1);
        tick(7);
        chk("abort_c17_lvl", Nivel_Comida, 1);
        tick(1);
        chk("abort_c18_lvl", Nivel_Comida, 0);
        chk("abort_c18_pulse", Pulso_Decay, 1);

        // ---- Enable low: button held but no feeding, decay continues
        apply_reset();
        tick(8);
        Activo_Comida = 1'b0;
        Boton_Comida  = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (Comiendo) bad++;
        end
        chk("enable_no_eat", bad, 0);
        chk("enable_decay_lvl", Nivel_Comida, 0);

        // ---- Async reset during COMIENDO at level 2
        apply_reset();
        tick(8);
        Activo_Comida = 1'b1;
        Boton_Comida  = 1'b1;
        tick(6);
        chk("rstmid_com", Comiendo, 1);
        chk("rstmid_lvl", Nivel_Comida, 2);
        tick(2);
        reset = 1'b0;
        #1;
        chk("rstmid_async_lvl", Nivel_Comida, 3);
        chk("rstmid_async_com", Comiendo, 0);
        chk("rstmid_async_pulse", Pulso_Decay, 0);
        #2;
        reset = 1'b1;
        tick(1);
        chk("rstmid_after_lvl", Nivel_Comida, 3);
        chk("rstmid_after_com", Comiendo, 0);
        tick(10);
        chk("rstmid_lleno_lvl", Nivel_Comida, 3);
        chk("rstmid_lleno_com", Comiendo, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
